// File: rtl/hazard_controller.sv
// Hazard controller for the five-stage pipeline: operand forwarding selects, load-use stalls and post-redirect flush.
// Define HAZARD_CONTROLLER_FORWARDING_EN to enable forwarding; otherwise every RAW dependency stalls.
module hazard_controller #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_use_rs,
    input  logic       i_id_use_rt,
    input  logic       i_id_ex_write_register,
    input  logic [4:0] i_id_ex_register_number,
    input  logic [1:0] i_id_ex_register_source,
    input  logic       i_ex_mem_write_register,
    input  logic [4:0] i_ex_mem_register_number,
    input  logic       i_redirect,
    output logic [1:0] o_forward_a,
    output logic [1:0] o_forward_b,
    output logic       o_pc_write,
    output logic       o_if_id_write,
    output logic       o_if_id_flush,
    output logic       o_id_ex_bubble,
    output logic       o_flushing
);

    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EXM  = 2'b01;
    localparam logic [1:0] FWD_MWB  = 2'b10;
    localparam logic [2:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_forward_a, r_forward_b;
    logic [1:0] w_forward_a_nxt, w_forward_b_nxt;

    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
    logic w_load_use, w_hazard, w_stall;

    function automatic logic producer_match(input logic wr, input logic [4:0] num,
                                            input logic [4:0] src_reg, input logic used);
        return wr && (num != 5'd0) && (num == src_reg) && used;
    endfunction

    // Nearest producer wins; a load still in ID/EX cannot be forwarded yet.
    function automatic logic [1:0] fwd_select(input logic ex_m, input logic mem_m,
                                              input logic [1:0] ex_src);
        if (ex_m && ex_src != SRC_MEM) return FWD_EXM;
        else if (mem_m)                return FWD_MWB;
        else                           return FWD_RF;
    endfunction

    assign w_ex_rs  = producer_match(i_id_ex_write_register, i_id_ex_register_number, i_id_rs, i_id_use_rs);
    assign w_ex_rt  = producer_match(i_id_ex_write_register, i_id_ex_register_number, i_id_rt, i_id_use_rt);
    assign w_mem_rs = producer_match(i_ex_mem_write_register, i_ex_mem_register_number, i_id_rs, i_id_use_rs);
    assign w_mem_rt = producer_match(i_ex_mem_write_register, i_ex_mem_register_number, i_id_rt, i_id_use_rt);

    assign w_load_use = (w_ex_rs || w_ex_rt) && (i_id_ex_register_source == SRC_MEM);

`ifdef HAZARD_CONTROLLER_FORWARDING_EN
    assign w_hazard = w_load_use;
`else
    // Without forwarding any in-flight producer of an operand blocks ID.
    assign w_hazard = w_load_use || w_ex_rs || w_ex_rt || w_mem_rs || w_mem_rt;
`endif

    assign w_stall = w_hazard && !i_redirect && (r_state == ST_RUN);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_redirect) begin
                    o_if_id_flush  = 1'b1;
                    o_id_ex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end else if (w_stall) begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Redirects seen here come from squashed instructions.
                o_if_id_flush  = 1'b1;
                o_id_ex_bubble = 1'b1;
                if (r_cnt == 3'd0) w_state_nxt = ST_RUN;
                else               w_cnt_nxt   = r_cnt - 3'd1;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_forward_a_nxt = FWD_RF;
        w_forward_b_nxt = FWD_RF;
`ifdef HAZARD_CONTROLLER_FORWARDING_EN
        if (!o_id_ex_bubble) begin
            w_forward_a_nxt = fwd_select(w_ex_rs, w_mem_rs, i_id_ex_register_source);
            w_forward_b_nxt = fwd_select(w_ex_rt, w_mem_rt, i_id_ex_register_source);
        end
`endif
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= 3'd0;
            r_forward_a <= FWD_RF;
            r_forward_b <= FWD_RF;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_forward_a <= w_forward_a_nxt;
            r_forward_b <= w_forward_b_nxt;
        end
    end

    assign o_forward_a = r_forward_a;
    assign o_forward_b = r_forward_b;
    assign o_flushing  = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: table of single-cycle hazard vectors plus stall/flush/reset sequences.
module tb_hazard_controller;

`ifdef HAZARD_CONTROLLER_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, exn, memn;
    logic       urs, urt, exw, memw, redirect;
    logic [1:0] exsrc;
    logic [1:0] fa, fb;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, flushing;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_controller #(.FLUSH_CYCLES(2)) dut (
        .i_clock                 (clk),
        .i_reset                 (rst),
        .i_id_rs                 (id_rs),
        .i_id_rt                 (id_rt),
        .i_id_use_rs             (urs),
        .i_id_use_rt             (urt),
        .i_id_ex_write_register  (exw),
        .i_id_ex_register_number (exn),
        .i_id_ex_register_source (exsrc),
        .i_ex_mem_write_register (memw),
        .i_ex_mem_register_number(memn),
        .i_redirect              (redirect),
        .o_forward_a             (fa),
        .o_forward_b             (fb),
        .o_pc_write              (pc_write),
        .o_if_id_write           (if_id_write),
        .o_if_id_flush           (if_id_flush),
        .o_id_ex_bubble          (id_ex_bubble),
        .o_flushing              (flushing)
    );

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       exw;
        logic [4:0] exn;
        logic [1:0] exsrc;
        logic       memw;
        logic [4:0] memn;
        logic       stall_f;
        logic [1:0] fa_f;
        logic [1:0] fb_f;
        logic       stall_n;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(string nm, logic [4:0] rs, logic ur, logic [4:0] rt, logic ut,
                                logic ew, logic [4:0] en, logic [1:0] es, logic mw, logic [4:0] mn,
                                logic sf, logic [1:0] af, logic [1:0] bf, logic sn);
        vec_t v;
        v.name = nm; v.rs = rs; v.urs = ur; v.rt = rt; v.urt = ut;
        v.exw = ew; v.exn = en; v.exsrc = es; v.memw = mw; v.memn = mn;
        v.stall_f = sf; v.fa_f = af; v.fb_f = bf; v.stall_n = sn;
        return v;
    endfunction

    task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ctrl(string tag, logic e_pc, logic e_ifid, logic e_fl, logic e_bub, logic e_fsm);
        chk({tag, ".pc_write"},     {1'b0, pc_write},     {1'b0, e_pc});
        chk({tag, ".if_id_write"},  {1'b0, if_id_write},  {1'b0, e_ifid});
        chk({tag, ".if_id_flush"},  {1'b0, if_id_flush},  {1'b0, e_fl});
        chk({tag, ".id_ex_bubble"}, {1'b0, id_ex_bubble}, {1'b0, e_bub});
        chk({tag, ".flushing"},     {1'b0, flushing},     {1'b0, e_fsm});
    endtask

    task automatic drive(logic [4:0] rs, logic ur, logic [4:0] rt, logic ut, logic ew,
                         logic [4:0] en, logic [1:0] es, logic mw, logic [4:0] mn, logic rd);
        id_rs = rs; urs = ur; id_rt = rt; urt = ut;
        exw = ew; exn = en; exsrc = es; memw = mw; memn = mn; redirect = rd;
    endtask

    task automatic quiet();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    endtask

    // Wait until just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic st;
        logic [1:0] ea, eb;

        //            name        rs  urs rt  urt exw exn src   mw  mn   stF faF    fbF    stN
        vecs[0]  = mk("idle",     0,  0,  0,  0,  0,  0,  2'b00, 0, 0,   0, 2'b00, 2'b00, 0);
        vecs[1]  = mk("alu_raw1", 5,  1,  6,  1,  1,  5,  2'b00, 0, 0,   0, 2'b01, 2'b00, 1);
        vecs[2]  = mk("load_rt",  4,  1,  3,  1,  1,  3,  2'b01, 0, 0,   1, 2'b00, 2'b00, 1);
        vecs[3]  = mk("reg_zero", 0,  1,  0,  1,  1,  0,  2'b01, 1, 0,   0, 2'b00, 2'b00, 0);
        vecs[4]  = mk("exmem_rs", 7,  1,  1,  1,  0,  0,  2'b00, 1, 7,   0, 2'b10, 2'b00, 1);
        vecs[5]  = mk("both_rt",  1,  1,  9,  1,  1,  9,  2'b00, 1, 9,   0, 2'b00, 2'b01, 1);
        vecs[6]  = mk("unused",   5,  0,  6,  0,  1,  5,  2'b00, 1, 6,   0, 2'b00, 2'b00, 0);
        vecs[7]  = mk("no_wr_ex", 5,  1,  6,  1,  0,  5,  2'b00, 0, 6,   0, 2'b00, 2'b00, 0);
        vecs[8]  = mk("pc4_src",  8,  1,  2,  1,  1,  8,  2'b10, 0, 0,   0, 2'b01, 2'b00, 1);
        vecs[9]  = mk("load_mix", 2,  1,  3,  1,  1,  3,  2'b01, 1, 2,   1, 2'b00, 2'b00, 1);
        vecs[10] = mk("same_reg", 12, 1,  12, 1,  1,  12, 2'b00, 0, 0,   0, 2'b01, 2'b01, 1);
        vecs[11] = mk("load_nu",  3,  0,  4,  1,  1,  3,  2'b01, 1, 4,   0, 2'b00, 2'b10, 1);
        vecs[12] = mk("no_wr_mm", 7,  1,  1,  0,  0,  0,  2'b00, 0, 7,   0, 2'b00, 2'b00, 0);

        // Reset with quiet inputs.
        rst = 1'b1;
        quiet();
        tick();
        tick();
        chk("rst.forward_a", fa, 2'b00);
        chk("rst.forward_b", fb, 2'b00);
        chk_ctrl("rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single-cycle vectors, each starting from RUN.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rs, vecs[i].urs, vecs[i].rt, vecs[i].urt, vecs[i].exw, vecs[i].exn,
                  vecs[i].exsrc, vecs[i].memw, vecs[i].memn, 1'b0);
            st = FWD ? vecs[i].stall_f : vecs[i].stall_n;
            ea = (FWD && !st) ? vecs[i].fa_f : 2'b00;
            eb = (FWD && !st) ? vecs[i].fb_f : 2'b00;
            #3;
            chk_ctrl(vecs[i].name, !st, !st, 1'b0, st, 1'b0);
            tick();
            chk({vecs[i].name, ".forward_a"}, fa, ea);
            chk({vecs[i].name, ".forward_b"}, fb, eb);
        end

        // Load-use on rt: load in ID/EX, then in EX/MEM, then gone.
        drive(4, 1, 3, 1, 1, 3, 2'b01, 0, 0, 1'b0);
        #3;
        chk_ctrl("lu0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("lu0.forward_b", fb, 2'b00);
        drive(4, 1, 3, 1, 0, 0, 2'b00, 1, 3, 1'b0);
        #3;
        if (FWD) chk_ctrl("lu1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        else     chk_ctrl("lu1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("lu1.forward_b", fb, FWD ? 2'b10 : 2'b00);
        chk("lu1.forward_a", fa, 2'b00);
        drive(4, 1, 3, 1, 0, 0, 2'b00, 0, 0, 1'b0);
        #3;
        chk_ctrl("lu2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lu2.forward_b", fb, 2'b00);

        // Redirect: two flush cycles; a second redirect inside FLUSH is ignored.
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1'b1);
        #3;
        chk_ctrl("rd_n", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        #3;
        chk_ctrl("rd_n1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        redirect = 1'b0;
        #3;
        chk_ctrl("rd_n2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // Redirect coinciding with a forwardable ALU RAW and a load-use: redirect wins.
        drive(5, 1, 3, 1, 1, 3, 2'b01, 1, 5, 1'b1);
        #3;
        chk_ctrl("rd_lu", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("rd_lu.forward_a", fa, 2'b00);
        chk("rd_lu.forward_b", fb, 2'b00);
        // Mid-FLUSH with the hazard still present, then reset.
        redirect = 1'b0;
        rst = 1'b1;
        #3;
        chk_ctrl("fl_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        quiet();
        #3;
        chk_ctrl("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst.forward_a", fa, 2'b00);
        chk("post_rst.forward_b", fb, 2'b00);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the five-stage CPU. It sits beside the ID/EX and EX/MEM registers and watches register numbers and write-back sources in ID, ID/EX and EX/MEM. From these it produces registered ALU-operand forwarding selects for the EX stage, load-use stall controls for PC and IF/ID, and a multi-cycle flush sequence after a taken branch or jump. It sequences and protects the EX stage; it does not touch data values.

## Interface
- FLUSH_CYCLES, default 2: number of consecutive cycles IF/ID and ID/EX are squashed after a redirect (legal range 1..7).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  the ID instruction reads rs / rt.
- id_ex_write_register  in  1  ID/EX instruction writes the register file.
- id_ex_register_number  in  5  destination register of the ID/EX instruction.
- id_ex_register_source  in  2  write-back source of the ID/EX instruction: 00 ALU, 01 memory, 10 pc4.
- ex_mem_write_register, ex_mem_register_number  in  1, 5  same meaning, for EX/MEM.
- redirect  in  1  taken branch or jump resolved in EX this cycle.
- forward_a, forward_b  out  2 each  registered operand selects used by EX: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back value.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID may load.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  load a NOP (all write enables 0) into ID/EX.
- flushing  out  1  FSM is in the FLUSH state.

## Operation
- Match rule: producer P matches ID operand X when P.write_register = 1, P.register_number ≠ 0, P.register_number = id_X, and id_use_X = 1.
- Load-use hazard: the ID/EX producer matches rs or rt, and id_ex_register_source = 01.
- stall = (load-use hazard) and not redirect and state = RUN.
- When stall = 1: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
- Forwarding is computed for the ID instruction and registered at the clock edge, so it applies when that instruction is in EX. Per operand X:
  - ID/EX producer matches and its source ≠ 01: select 01.
  - Otherwise, EX/MEM producer matches: select 10.
  - Otherwise: select 00.
  - ID/EX beats EX/MEM when both match.
- When the cycle bubbles ID/EX (stall or flush), forward_a and forward_b are loaded with 00.
- FSM states: RUN and FLUSH, with a 3-bit counter cnt.
- RUN with redirect = 1:
  - if_id_flush = 1, id_ex_bubble = 1, pc_write = 1, if_id_write = 1, stall suppressed.
  - If FLUSH_CYCLES > 1: go to FLUSH with cnt = FLUSH_CYCLES − 2. Otherwise stay in RUN.
- FLUSH:
  - if_id_flush = 1, id_ex_bubble = 1, pc_write = 1, if_id_write = 1.
  - redirect is ignored, because it comes from a squashed instruction.
  - When cnt = 0, return to RUN. Otherwise decrement cnt.
- RUN with no hazard and no redirect: pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_bubble = 0.

## Timing
- After the reset edge: state RUN, cnt 0, forward_a = forward_b = 00, flushing 0. pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_bubble = 0, unless the comparators currently indicate a hazard.
- Reset has priority over everything, including mid-FLUSH. A reset edge during FLUSH returns to RUN immediately.
- Stall and flush controls are combinational from the current inputs and state, and are valid in the same cycle.
- Forward selects have 1-cycle latency: they are computed in cycle n and drive EX in cycle n+1.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load sits in EX/MEM and the ID instruction receives select 10.
- A redirect produces FLUSH_CYCLES cycles with if_id_flush = 1, starting in the redirect cycle.
- If redirect and a load-use hazard occur in the same cycle, redirect wins and no stall is asserted.

## Configuration
- HAZARD_CONTROLLER_FORWARDING_EN defined: forwarding operates as described above.
- HAZARD_CONTROLLER_FORWARDING_EN undefined:
  - forward_a and forward_b are held at 00.
  - A match against either the ID/EX or the EX/MEM producer, with any write-back source, raises stall.
  - RAW distance 1 gives a 2-cycle stall; distance 2 gives a 1-cycle stall.
  - The redirect and flush behaviour is unchanged.

## Test plan
- ALU RAW at distance 1: ID/EX writes r5 with source 00, ID reads rs = r5 → no stall; forward_a = 01 after the next edge; forward_b = 00.
- Load-use: ID/EX writes r3 with source 01, ID reads rt = r3 → pc_write = 0, if_id_write = 0, id_ex_bubble = 1 for one cycle; next cycle forward_b = 10; then normal flow resumes.
- Register zero: a producer writes r0 and ID reads r0 → no stall, selects remain 00.
- Redirect with FLUSH_CYCLES = 2: redirect pulses in cycle n → if_id_flush = 1 in n and n+1; flushing = 1 in n+1; back to RUN in n+2; a redirect in n+1 is ignored.
- Redirect coinciding with load-use → pc_write = 1, no stall, id_ex_bubble = 1. Reset asserted mid-FLUSH → RUN with all forwards at 00 after the edge.
- Macro undefined: EX/MEM writes r7, ID reads r7 → 1-cycle stall and forward_a stays 00.
